// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display: segment codes
// {g,f,e,d,c,b,a} and anode enables (both active-low), plus the scan FSM states.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } state_t;

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        case (idx)
            2'd0:    anode_for = AN_D0;
            2'd1:    anode_for = AN_D1;
            2'd2:    anode_for = AN_D2;
            default: anode_for = AN_D3;
        endcase
    endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational BCD-to-7-segment decoder (active-low). Values 10..15 show 'E';
// the blank flag forces all segments off.
module decodificador_7seg
    import display_pkg::*;
(
    input  logic [3:0] digito,
    input  logic       apagar,
    output logic [6:0] segmentos
);

    always_comb begin
        segmentos = SEG_E;
        if (apagar) begin
            segmentos = SEG_BLANK;
        end else begin
            case (digito)
                4'd0:    segmentos = SEG_0;
                4'd1:    segmentos = SEG_1;
                4'd2:    segmentos = SEG_2;
                4'd3:    segmentos = SEG_3;
                4'd4:    segmentos = SEG_4;
                4'd5:    segmentos = SEG_5;
                4'd6:    segmentos = SEG_6;
                4'd7:    segmentos = SEG_7;
                4'd8:    segmentos = SEG_8;
                4'd9:    segmentos = SEG_9;
                default: segmentos = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/display_mux_7seg.sv
// Latches a signed BCD number on load and scans it onto a 4-digit common-anode
// display with a blanking cycle per digit switch. Define DISPLAY_ZERO_BLANK_EN for leading-zero suppression.
module display_mux_7seg
    import display_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int CNT_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] centena,
    input  logic [3:0] dezena,
    input  logic [3:0] unidade,
    input  logic       neg,
    output logic [3:0] anodo,
    output logic [6:0] segmentos
);

`ifdef DISPLAY_ZERO_BLANK_EN
    localparam bit ZERO_BLANK = 1'b1;
`else
    localparam bit ZERO_BLANK = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DIV - 1);

    logic [3:0]       centena_q, dezena_q, unidade_q;
    logic             neg_q;
    logic [CNT_W-1:0] prescaler;
    logic             tick;
    state_t           state, next_state;
    logic [1:0]       idx, next_idx;
    logic [3:0]       anodo_next;
    logic [6:0]       segmentos_next;
    logic [3:0]       dec_digito;
    logic             dec_apagar;
    logic [6:0]       dec_segmentos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            centena_q <= 4'd0;
            dezena_q  <= 4'd0;
            unidade_q <= 4'd0;
            neg_q     <= 1'b0;
        end else if (load) begin
            centena_q <= centena;
            dezena_q  <= dezena;
            unidade_q <= unidade;
            neg_q     <= neg;
        end
    end

    // The prescaler wraps together with the slot end, so it is 0 during every BLANK cycle.
    assign tick = (prescaler == LAST_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BLANK;
            idx   <= 2'd0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = idx;
        case (state)
            BLANK: next_state = SCAN;
            SCAN: begin
                if (tick) begin
                    next_state = BLANK;
                    next_idx   = idx + 2'd1;
                end
            end
            default: next_state = BLANK;
        endcase
    end

    always_comb begin
        dec_digito = unidade_q;
        dec_apagar = 1'b0;
        case (idx)
            2'd0: dec_digito = unidade_q;
            2'd1: begin
                dec_digito = dezena_q;
                dec_apagar = ZERO_BLANK && (centena_q == 4'd0) && (dezena_q == 4'd0);
            end
            2'd2: begin
                dec_digito = centena_q;
                dec_apagar = ZERO_BLANK && (centena_q == 4'd0);
            end
            default: begin
                dec_digito = 4'd0;
                dec_apagar = 1'b1;
            end
        endcase
    end

    decodificador_7seg u_decodificador (
        .digito    (dec_digito),
        .apagar    (dec_apagar),
        .segmentos (dec_segmentos)
    );

    // The sign slot bypasses the decoder since minus is not a BCD value.
    always_comb begin
        anodo_next     = AN_OFF;
        segmentos_next = SEG_BLANK;
        if (state == SCAN) begin
            anodo_next = anode_for(idx);
            if (idx == 2'd3) begin
                segmentos_next = neg_q ? SEG_MINUS : SEG_BLANK;
            end else begin
                segmentos_next = dec_segmentos;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anodo     <= AN_OFF;
            segmentos <= SEG_BLANK;
        end else begin
            anodo     <= anodo_next;
            segmentos <= segmentos_next;
        end
    end

endmodule

// File: tb/tb_display_mux_7seg.sv
// Self-checking bench for display_mux_7seg (DIV=4): directed cases plus random loads,
// compared every cycle against a timing/digit model derived from the edge count since reset.
module tb_display_mux_7seg;

    localparam int DIV   = 4;
    localparam int CNT_W = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] centena = 4'd0;
    logic [3:0] dezena = 4'd0;
    logic [3:0] unidade = 4'd0;
    logic       neg = 1'b0;
    logic [3:0] anodo;
    logic [6:0] segmentos;

    int checks = 0;
    int failures = 0;

    int         edgeCount = 0;
    logic [3:0] mC = 4'd0, mD = 4'd0, mU = 4'd0;
    logic       mNeg = 1'b0;

    display_mux_7seg #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .centena   (centena),
        .dezena    (dezena),
        .unidade   (unidade),
        .neg       (neg),
        .anodo     (anodo),
        .segmentos (segmentos)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [10:0] observed, input logic [10:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed an=%b seg=%b expected an=%b seg=%b at t=%0t",
                     tag, observed[10:7], observed[6:0], expected[10:7], expected[6:0], $time);
        end
    endtask

    function automatic logic [6:0] segOf(input logic [3:0] v);
        logic [6:0] table10 [10];
        table10 = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (v > 4'd9) return 7'b0000110;
        return table10[v];
    endfunction

    // Output after edge n reflects the slot position reached after edge n-1.
    function automatic logic [10:0] expectedOut(input int n);
        int pos, digit;
        bit zb;
        logic [6:0] seg;
        zb = 1'b0;
`ifdef DISPLAY_ZERO_BLANK_EN
        zb = 1'b1;
`endif
        if (n <= 0) return {4'b1111, 7'b1111111};
        pos   = (n - 1) % DIV;
        digit = ((n - 1) / DIV) % 4;
        if (pos == 0) return {4'b1111, 7'b1111111};
        case (digit)
            0: seg = segOf(mU);
            1: seg = (zb && mC == 4'd0 && mD == 4'd0) ? 7'b1111111 : segOf(mD);
            2: seg = (zb && mC == 4'd0) ? 7'b1111111 : segOf(mC);
            default: seg = mNeg ? 7'b0111111 : 7'b1111111;
        endcase
        return {~(4'b0001 << digit), seg};
    endfunction

    task automatic applyStimulus(input logic ld, input logic [3:0] c, input logic [3:0] d,
                                 input logic [3:0] u, input logic n);
        load    = ld;
        centena = c;
        dezena  = d;
        unidade = u;
        neg     = n;
    endtask

    task automatic stepCycle(input string tag);
        logic [10:0] exp;
        @(posedge clk);
        edgeCount++;
        exp = expectedOut(edgeCount);
        if (load) begin
            mC = centena; mD = dezena; mU = unidade; mNeg = neg;
        end
        @(negedge clk);
        checkOutput(tag, {anodo, segmentos}, exp);
    endtask

    task automatic runIdle(input int cycles, input string tag);
        load = 1'b0;
        repeat (cycles) stepCycle(tag);
    endtask

    task automatic loadAndRun(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                              input logic n, input string tag);
        applyStimulus(1'b1, c, d, u, n);
        stepCycle(tag);
        runIdle(2 * 4 * DIV, tag);
    endtask

    // Reset is raised between edges and must clear the outputs without waiting for a clock.
    task automatic doReset(input string tag);
        #2 rst = 1'b1;
        #1 checkOutput({tag, "_async"}, {anodo, segmentos}, {4'b1111, 7'b1111111});
        @(negedge clk);
        checkOutput({tag, "_held"}, {anodo, segmentos}, {4'b1111, 7'b1111111});
        rst = 1'b0;
        edgeCount = 0;
        mC = 4'd0; mD = 4'd0; mU = 4'd0; mNeg = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        checkOutput("reset_init", {anodo, segmentos}, {4'b1111, 7'b1111111});
        rst = 1'b0;
        runIdle(2, "post_reset_blank");
        runIdle(2 * 4 * DIV, "post_reset_zero");

        loadAndRun(4'd1, 4'd2, 4'd7, 1'b0, "load_127");
        loadAndRun(4'd1, 4'd2, 4'd8, 1'b1, "load_neg128");
        loadAndRun(4'd3, 4'd4, 4'hC, 1'b0, "units_error");
        loadAndRun(4'd0, 4'd0, 4'd5, 1'b1, "load_neg005");
        loadAndRun(4'hF, 4'hA, 4'd0, 1'b0, "tens_hund_error");

        applyStimulus(1'b1, 4'd9, 4'd9, 4'd9, 1'b0);
        stepCycle("b2b_first");
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd1, 1'b0);
        stepCycle("b2b_second");
        runIdle(2 * 4 * DIV, "b2b_last_wins");

        runIdle(DIV + 2, "pre_midscan_reset");
        doReset("midscan_reset");
        runIdle(2 * 4 * DIV, "post_midscan_reset");

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
            stepCycle("random");
        end

        applyStimulus(1'b1, 4'd6, 4'd0, 4'd3, 1'b1);
        stepCycle("random_tail_load");
        runIdle(DIV + 1, "random_tail");
        doReset("final_reset");
        runIdle(DIV + 2, "final_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
